// File: rtl/grf_bypass.sv
// 32 x 32 general register file with write-to-read bypass.
// Also records the last effective write for the commit log.
module grf_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       wb_pc,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              commit_vld,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic [31:0]       commit_pc
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // Reset outranks the write, and r0 is never written.
  assign wr_en = we && (a3 != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      commit_vld  <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
      commit_pc   <= '0;
    end else begin
      commit_vld <= wr_en;
      if (wr_en) begin
        regs[a3]    <= wd;
        commit_addr <= a3;
        commit_data <= wd;
        commit_pc   <= wb_pc;
      end
    end
  end

  // wr_en implies a3 != 0, so the two hit terms never overlap.
  always_comb begin
    rd1 = regs[a1];
    unique case (1'b1)
      (a1 == '0):             rd1 = '0;
      (wr_en && (a3 == a1)): rd1 = wd;
      default:                rd1 = regs[a1];
    endcase
  end

  always_comb begin
    rd2 = regs[a2];
    unique case (1'b1)
      (a2 == '0):             rd2 = '0;
      (wr_en && (a3 == a2)): rd2 = wd;
      default:                rd2 = regs[a2];
    endcase
  end

endmodule
